instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 130 +++++++++++++
 tb/tb_instr_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32 instruction encoder (R/I/S/B formats) feeding a small valid/ready output FIFO.
// Optional immediate range checking is enabled by defining BRISC_ENC_IMM_CHECK_EN.
package brisc_pkg;
  parameter int unsigned ILEN = 32;

  typedef enum logic [2:0] {
    ITYPE_R       = 3'd0,
    ITYPE_I       = 3'd1,
    ITYPE_S       = 3'd2,
    ITYPE_B       = 3'd3,
    ITYPE_INVALID = 3'd7
  } itype_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
endpackage

module instr_encoder #(
  parameter int unsigned ILEN  = brisc_pkg::ILEN,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  brisc_pkg::itype_e       in_itype,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [2:0]              in_funct3,
  input  logic [6:0]              in_funct7,
  input  logic [31:0]             in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ILEN-1:0]         out_instr,
  output logic                    err,
  output logic [31:0]             enc_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ILEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            err_q, err_d;
  logic [31:0]     enc_count_q, enc_count_d;

  logic [ILEN-1:0] word;
  logic            encodable;
  logic            accept, push, pop;

  always_comb begin
    word      = '0;
    encodable = 1'b1;
    case (in_itype)
      brisc_pkg::ITYPE_R:
        word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, brisc_pkg::OPCODE_OP};
      brisc_pkg::ITYPE_I: begin
        word = {in_imm[11:0], in_rs1, in_funct3, in_rd, brisc_pkg::OPCODE_LOAD};
`ifdef BRISC_ENC_IMM_CHECK_EN
        if ($signed(in_imm) < -32'sd2048 || $signed(in_imm) > 32'sd2047) encodable = 1'b0;
`endif
      end
      brisc_pkg::ITYPE_S: begin
        word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], brisc_pkg::OPCODE_STORE};
`ifdef BRISC_ENC_IMM_CHECK_EN
        if ($signed(in_imm) < -32'sd2048 || $signed(in_imm) > 32'sd2047) encodable = 1'b0;
`endif
      end
      brisc_pkg::ITYPE_B: begin
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11],
                brisc_pkg::OPCODE_BRANCH};
`ifdef BRISC_ENC_IMM_CHECK_EN
        if ($signed(in_imm) < -32'sd4096 || $signed(in_imm) > 32'sd4094 || in_imm[0])
          encodable = 1'b0;
`endif
      end
      default: encodable = 1'b0;
    endcase
  end

  // in_ready is a register derived from next-state occupancy, so it never sees out_ready combinationally.
  always_comb begin
    accept      = in_valid & in_ready_q;
    push        = accept & encodable;
    pop         = (count_q != '0) & out_ready;
    err_d       = accept & ~encodable;
    wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    in_ready_d  = (count_d != CW'(DEPTH));
    enc_count_d = push ? enc_count_q + 32'd1 : enc_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      err_q       <= 1'b0;
      enc_count_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= word;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign out_instr = mem_q[rptr_q];
  assign err       = err_q;
  assign enc_count = enc_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: queue-based reference model checked every cycle plus literal expectations.
module tb_instr_encoder;
  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  brisc_pkg::itype_e in_itype;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic              err;
  logic [31:0]       enc_count;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  instr_encoder #(.ILEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_itype(in_itype),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: field placement by shifts and masks on the integer immediate.
  function automatic logic [31:0] model_enc(input brisc_pkg::itype_e t, input int unsigned rd,
      input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
      input int unsigned f7, input int imm, output bit ok);
    int unsigned u;
    int unsigned w;
    u  = imm;
    ok = 1'b1;
    w  = 0;
    case (t)
      brisc_pkg::ITYPE_R: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      brisc_pkg::ITYPE_I: begin
        w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
`ifdef BRISC_ENC_IMM_CHECK_EN
        ok = (imm >= -2048) && (imm <= 2047);
`endif
      end
      brisc_pkg::ITYPE_S: begin
        w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((u & 32'h1F) << 7) | 32'h23;
`ifdef BRISC_ENC_IMM_CHECK_EN
        ok = (imm >= -2048) && (imm <= 2047);
`endif
      end
      brisc_pkg::ITYPE_B: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
`ifdef BRISC_ENC_IMM_CHECK_EN
        ok = (imm >= -4096) && (imm <= 4094) && ((imm % 2) == 0);
`endif
      end
      default: ok = 1'b0;
    endcase
    return w;
  endfunction

  logic [31:0] mq[$];
  logic [31:0] m_cnt = 0;
  bit          m_err = 1'b0;
  bit          m_ready = 1'b1;

  always @(posedge clk) begin
    bit acc, pop, ok;
    logic [31:0] w;
    if (reset) begin
      mq.delete();
      m_cnt   = 0;
      m_err   = 1'b0;
      m_ready = 1'b1;
    end else begin
      acc   = in_valid && m_ready;
      pop   = (mq.size() != 0) && out_ready;
      m_err = 1'b0;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        w = model_enc(in_itype, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ok);
        if (ok) begin
          mq.push_back(w);
          m_cnt = m_cnt + 1;
        end else m_err = 1'b1;
      end
      m_ready = (mq.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0 && out_valid) chk("out_instr", out_instr, mq[0]);
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("enc_count", enc_count, m_cnt);
    end
  end

  // Call at a negedge; returns at the negedge following the accepting edge with in_valid still high.
  task automatic send(input brisc_pkg::itype_e t, input int rd, input int rs1, input int rs2,
      input int f3, input int f7, input int imm);
    int n;
    n         = 0;
    in_itype  = t;
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = imm;
    in_valid  = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [31:0] base;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_itype = brisc_pkg::ITYPE_R; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    chk("model_R", model_enc(brisc_pkg::ITYPE_R, 3, 1, 2, 0, 0, 0, ok), 32'h002081B3);
    chk("model_I", model_enc(brisc_pkg::ITYPE_I, 5, 10, 0, 2, 0, 8, ok), 32'h00852283);
    chk("model_S", model_enc(brisc_pkg::ITYPE_S, 0, 2, 6, 2, 0, 12, ok), 32'h00612623);
    chk("model_B", model_enc(brisc_pkg::ITYPE_B, 0, 1, 2, 0, 0, 8, ok), 32'h00208463);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_enc_count", enc_count, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    send(brisc_pkg::ITYPE_R, 3, 1, 2, 0, 0, 0);
    chk("R_word", out_instr, 32'h002081B3);
    chk("R_valid", {31'd0, out_valid}, 32'd1);
    chk("R_count", enc_count, 32'd1);
    idle(2);

    send(brisc_pkg::ITYPE_I, 5, 10, 0, 2, 0, 8);
    chk("I_word", out_instr, 32'h00852283);
    send(brisc_pkg::ITYPE_S, 0, 2, 6, 2, 0, 12);
    chk("S_word", out_instr, 32'h00612623);
    send(brisc_pkg::ITYPE_B, 0, 1, 2, 0, 0, 8);
    chk("B_word", out_instr, 32'h00208463);
    idle(2);

    send(brisc_pkg::ITYPE_B, 7, 31, 17, 5, 0, -4096);
    send(brisc_pkg::ITYPE_S, 0, 9, 4, 1, 0, -1);
    send(brisc_pkg::ITYPE_R, 31, 30, 29, 7, 7'h20, 0);
    idle(3);

    do_reset();
    out_ready = 1'b0;
    send(brisc_pkg::ITYPE_I, 1, 2, 0, 0, 0, 100);
    send(brisc_pkg::ITYPE_I, 2, 3, 0, 1, 0, -100);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_itype = brisc_pkg::ITYPE_S; in_rs1 = 5'd4; in_rs2 = 5'd5; in_imm = 32'd20; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_count", enc_count, 32'd2);
    out_ready = 1'b1;
    send(brisc_pkg::ITYPE_S, 0, 4, 5, 2, 0, 20);
    idle(3);
    chk("stall_total", enc_count, 32'd3);

    base = enc_count;
    send(brisc_pkg::ITYPE_INVALID, 1, 1, 1, 0, 0, 0);
    chk("inv_err", {31'd0, err}, 32'd1);
    chk("inv_valid", {31'd0, out_valid}, 32'd0);
    chk("inv_count", enc_count, base);
    idle(1);
    chk("inv_err_clear", {31'd0, err}, 32'd0);

    send(brisc_pkg::ITYPE_I, 0, 0, 0, 0, 0, 2048);
`ifdef BRISC_ENC_IMM_CHECK_EN
    chk("imm2048_err", {31'd0, err}, 32'd1);
    chk("imm2048_valid", {31'd0, out_valid}, 32'd0);
`else
    chk("imm2048_word", out_instr, 32'h80000003);
    chk("imm2048_err", {31'd0, err}, 32'd0);
`endif
    send(brisc_pkg::ITYPE_B, 0, 1, 1, 0, 0, 9);
    send(brisc_pkg::ITYPE_S, 0, 1, 1, 0, 0, -2049);
    idle(3);

    out_ready = 1'b0;
    send(brisc_pkg::ITYPE_R, 1, 2, 3, 4, 5, 0);
    send(brisc_pkg::ITYPE_R, 6, 7, 8, 1, 2, 0);
    idle(1);
    do_reset();
    chk("rr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rr_enc_count", enc_count, 32'd0);
    chk("rr_err", {31'd0, err}, 32'd0);
    out_ready = 1'b1;
    idle(3);
    chk("rr_no_stale", {31'd0, out_valid}, 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
